// File: rtl/video_unpack_pkg.sv
// Shared helpers for the video FIFO unpacker: slot-order encodings and
// the sizing functions used by the unpack datapath and request generator.
package video_unpack_pkg;

  localparam logic SLOT_MSB_FIRST = 1'b0;
  localparam logic SLOT_LSB_FIRST = 1'b1;

  function automatic int slots_per_word(input int fifo_w, input int slot_w);
    return fifo_w / slot_w;
  endfunction

  // Pending-request counter must hold 0..req_q_max inclusive.
  function automatic int pend_width(input int req_q_max);
    return (req_q_max < 1) ? 1 : $clog2(req_q_max + 1);
  endfunction

endpackage

// File: rtl/video_burst_req_gen.sv
// Line-granular burst request generator: prefetch on the first vs_in falling
// edge, then one request per de_in falling edge once a handshake has occurred.
module video_burst_req_gen
  import video_unpack_pkg::*;
#(
  parameter int PREFETCH_LINES = 2,
  parameter int REQ_Q_MAX      = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic vs_in,
  input  logic de_in,
  input  logic burst_ready,
  output logic burst_valid,
  output logic req_drop
);

  localparam int PEND_W = pend_width(REQ_Q_MAX);

  logic              vs_dly_q, vs_dly_d;
  logic              de_dly_q, de_dly_d;
  logic              started_q, started_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              burst_valid_q, burst_valid_d;
  logic              req_drop_q, req_drop_d;
  logic              event_s, handshake_s;
  int                add_s, net_s;

  always_comb begin
    vs_dly_d    = vs_in;
    de_dly_d    = de_in;
    event_s     = started_q ? (de_dly_q & ~de_in) : (vs_dly_q & ~vs_in);
    add_s       = event_s ? (started_q ? 1 : PREFETCH_LINES) : 0;
    handshake_s = burst_valid_q & burst_ready;
    net_s       = int'(pend_q) + add_s - (handshake_s ? 1 : 0);
    started_d   = started_q | handshake_s;
    req_drop_d  = req_drop_q;
    if (net_s > REQ_Q_MAX) begin
      pend_d     = PEND_W'(REQ_Q_MAX);
      req_drop_d = 1'b1;
    end else begin
      pend_d     = PEND_W'(net_s);
    end
    // Registered so burst_valid tracks pend without a combinational path.
    burst_valid_d = (pend_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_dly_q      <= 1'b0;
      de_dly_q      <= 1'b0;
      started_q     <= 1'b0;
      pend_q        <= '0;
      burst_valid_q <= 1'b0;
      req_drop_q    <= 1'b0;
    end else begin
      vs_dly_q      <= vs_dly_d;
      de_dly_q      <= de_dly_d;
      started_q     <= started_d;
      pend_q        <= pend_d;
      burst_valid_q <= burst_valid_d;
      req_drop_q    <= req_drop_d;
    end
  end

  assign burst_valid = burst_valid_q;
  assign req_drop    = req_drop_q;

endmodule

// File: rtl/video_fifo_unpacker.sv
// Unpacks FWFT FIFO words into a two-stage registered pixel stream and issues
// line requests. Optional underflow counter: UNPACKER_UNDERFLOW_CNT_EN.
module video_fifo_unpacker
  import video_unpack_pkg::*;
#(
  parameter int               FIFO_W         = 128,
  parameter int               SLOT_W         = 32,
  parameter int               PIX_W          = 24,
  parameter int               PREFETCH_LINES = 2,
  parameter int               REQ_Q_MAX      = 4,
  parameter logic [PIX_W-1:0] UNDERFLOW_PIX  = '0
) (
  input  logic              video_clk,
  input  logic              video_rst,
  input  logic              vs_in,
  input  logic              hs_in,
  input  logic              de_in,
  input  logic              data_req_in,
  input  logic              lsb_first,
  input  logic [FIFO_W-1:0] fifo_data_in,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic              vs_out,
  output logic              hs_out,
  output logic              de_out,
  output logic [PIX_W-1:0]  pixel_out,
  output logic              burst_valid,
  input  logic              burst_ready,
  output logic [15:0]       underflow_cnt,
  output logic              req_drop
);

  localparam int               N        = slots_per_word(FIFO_W, SLOT_W);
  localparam int               IDX_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  logic             vs_prev_q, vs_prev_d;
  logic             order_q, order_d;
  logic [IDX_W-1:0] slot_idx_q, slot_idx_d;
  logic [PIX_W-1:0] pix1_q, pix1_d;
  logic [PIX_W-1:0] pixel_out_q, pixel_out_d;
  logic             vs_out_q, vs_out_d, hs_out_q, hs_out_d, de_out_q, de_out_d;
  logic             resync_s;
  logic [IDX_W-1:0] idx_eff_s, sel_s;
  logic [PIX_W-1:0] slot_pix_s;

  // Resync on vs_in rise wins over a coincident request: that pixel uses slot 0.
  always_comb begin
    resync_s   = vs_in & ~vs_prev_q;
    vs_prev_d  = vs_in;
    order_d    = resync_s ? lsb_first : order_q;
    idx_eff_s  = resync_s ? '0 : slot_idx_q;
    sel_s      = (order_d == SLOT_LSB_FIRST) ? idx_eff_s : (LAST_IDX - idx_eff_s);
    slot_pix_s = fifo_data_in[int'(sel_s)*SLOT_W +: PIX_W];
    fifo_rd_en = data_req_in & ~fifo_empty & (idx_eff_s == LAST_IDX);
    slot_idx_d = idx_eff_s;
    pix1_d     = pix1_q;
    if (data_req_in) begin
      slot_idx_d = (idx_eff_s == LAST_IDX) ? '0 : (idx_eff_s + IDX_W'(1));
      pix1_d     = fifo_empty ? UNDERFLOW_PIX : slot_pix_s;
    end
    pixel_out_d = pix1_q;
    vs_out_d    = vs_in;
    hs_out_d    = hs_in;
    de_out_d    = de_in;
  end

  always_ff @(posedge video_clk) begin
    if (video_rst) begin
      vs_prev_q   <= 1'b0;
      order_q     <= SLOT_MSB_FIRST;
      slot_idx_q  <= '0;
      pix1_q      <= '0;
      pixel_out_q <= '0;
      vs_out_q    <= 1'b0;
      hs_out_q    <= 1'b0;
      de_out_q    <= 1'b0;
    end else begin
      vs_prev_q   <= vs_prev_d;
      order_q     <= order_d;
      slot_idx_q  <= slot_idx_d;
      pix1_q      <= pix1_d;
      pixel_out_q <= pixel_out_d;
      vs_out_q    <= vs_out_d;
      hs_out_q    <= hs_out_d;
      de_out_q    <= de_out_d;
    end
  end

  assign pixel_out = pixel_out_q;
  assign vs_out    = vs_out_q;
  assign hs_out    = hs_out_q;
  assign de_out    = de_out_q;

`ifdef UNPACKER_UNDERFLOW_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (data_req_in && fifo_empty && (ucnt_q != 16'hFFFF)) begin
      ucnt_d = ucnt_q + 16'd1;
    end
  end

  always_ff @(posedge video_clk) begin
    if (video_rst) begin
      ucnt_q <= 16'd0;
    end else begin
      ucnt_q <= ucnt_d;
    end
  end

  assign underflow_cnt = ucnt_q;
`else
  assign underflow_cnt = 16'h0000;
`endif

  video_burst_req_gen #(
    .PREFETCH_LINES (PREFETCH_LINES),
    .REQ_Q_MAX      (REQ_Q_MAX)
  ) u_req_gen (
    .clk         (video_clk),
    .rst         (video_rst),
    .vs_in       (vs_in),
    .de_in       (de_in),
    .burst_ready (burst_ready),
    .burst_valid (burst_valid),
    .req_drop    (req_drop)
  );

endmodule

// File: tb/tb_video_fifo_unpacker.sv
// Self-checking bench for video_fifo_unpacker: vector table with a pixel
// scoreboard, plus hand-written request-generator and reset sequences.
module tb_video_fifo_unpacker;

  logic         video_clk = 1'b0;
  logic         video_rst, vs_in, hs_in, de_in, data_req_in, lsb_first;
  logic [127:0] fifo_data_in;
  logic         fifo_empty, fifo_rd_en, vs_out, hs_out, de_out;
  logic [23:0]  pixel_out;
  logic         burst_valid, burst_ready, req_drop;
  logic [15:0]  underflow_cnt;

  int          errors = 0;
  int          checks = 0;
  logic [23:0] exp_q[$];
  bit          mon_en = 1'b0;
  logic        req_prev = 1'b0;

  localparam logic [127:0] WORD = 128'h00AABBCC_00112233_00445566_00778899;

  typedef struct {
    logic        req;
    logic        empty;
    logic        vs;
    logic        lsb;
    logic        exp_rd;
    logic [23:0] exp_pix;
  } vec_t;
  vec_t vecs[$];

  always #5 video_clk = ~video_clk;

  video_fifo_unpacker dut (
    .video_clk     (video_clk),
    .video_rst     (video_rst),
    .vs_in         (vs_in),
    .hs_in         (hs_in),
    .de_in         (de_in),
    .data_req_in   (data_req_in),
    .lsb_first     (lsb_first),
    .fifo_data_in  (fifo_data_in),
    .fifo_empty    (fifo_empty),
    .fifo_rd_en    (fifo_rd_en),
    .vs_out        (vs_out),
    .hs_out        (hs_out),
    .de_out        (de_out),
    .pixel_out     (pixel_out),
    .burst_valid   (burst_valid),
    .burst_ready   (burst_ready),
    .underflow_cnt (underflow_cnt),
    .req_drop      (req_drop)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: each de_out pixel is matched against the oldest expected pixel.
  always @(negedge video_clk) begin
    if (mon_en && de_out) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pixel_unexpected: got %0h expected no pixel", pixel_out);
      end else begin
        check("pixel", 32'(pixel_out), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic step(input vec_t v);
    @(posedge video_clk);
    #1;
    de_in        = req_prev;
    req_prev     = v.req;
    data_req_in  = v.req;
    fifo_empty   = v.empty;
    vs_in        = v.vs;
    lsb_first    = v.lsb;
    fifo_data_in = WORD;
    @(negedge video_clk);
    check("fifo_rd_en", 32'(fifo_rd_en), 32'(v.exp_rd));
    if (v.req) exp_q.push_back(v.exp_pix);
  endtask

  task automatic bcyc(input logic vs, input logic de, input logic rdy);
    @(posedge video_clk);
    #1;
    vs_in       = vs;
    de_in       = de;
    burst_ready = rdy;
    @(negedge video_clk);
  endtask

  task automatic do_reset();
    @(posedge video_clk);
    #1;
    video_rst = 1'b1;
    vs_in = 1'b0; hs_in = 1'b0; de_in = 1'b0; data_req_in = 1'b0;
    fifo_empty = 1'b0; burst_ready = 1'b0; lsb_first = 1'b0;
    req_prev = 1'b0;
    repeat (2) @(posedge video_clk);
    #1;
    video_rst = 1'b0;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) step(vecs[i]);
  endtask

  task automatic add(input logic r, input logic e, input logic v, input logic l,
                     input logic rd, input logic [23:0] p);
    vec_t t;
    t.req = r; t.empty = e; t.vs = v; t.lsb = l; t.exp_rd = rd; t.exp_pix = p;
    vecs.push_back(t);
  endtask

  initial begin
    int n_hs;
    logic [15:0] exp_ucnt3, exp_ucnt4;
`ifdef UNPACKER_UNDERFLOW_CNT_EN
    exp_ucnt3 = 16'd3;
    exp_ucnt4 = 16'd4;
`else
    exp_ucnt3 = 16'd0;
    exp_ucnt4 = 16'd0;
`endif
    video_rst = 1'b1; vs_in = 1'b0; hs_in = 1'b0; de_in = 1'b0;
    data_req_in = 1'b0; lsb_first = 1'b0; fifo_data_in = WORD;
    fifo_empty = 1'b0; burst_ready = 1'b0;

    // MSB-first word, then LSB-first after a vs rise, then underflows.
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'hAABBCC);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h112233);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h445566);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 24'h778899);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000);
    add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24'h778899);
    add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24'h445566);
    add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24'h112233);
    add(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 24'hAABBCC);
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000000);
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000000);
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000000);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000);   // index 13: count check point
    add(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 24'hAABBCC);
    add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24'h778899);
    add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24'h445566);
    add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 24'h778899);   // resync at slot_idx 2
    add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 24'h445566);
    add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24'h112233);
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000000);   // underflow at last slot
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000);

    do_reset();
    @(negedge video_clk);
    check("rst_pixel_out", 32'(pixel_out), 32'h0);
    check("rst_de_out", 32'(de_out), 32'h0);
    check("rst_burst_valid", 32'(burst_valid), 32'h0);
    check("rst_fifo_rd_en", 32'(fifo_rd_en), 32'h0);
    check("rst_underflow_cnt", 32'(underflow_cnt), 32'h0);
    check("rst_req_drop", 32'(req_drop), 32'h0);

    mon_en = 1'b1;
    run_vecs(0, 13);
    check("underflow_cnt_3", 32'(underflow_cnt), 32'(exp_ucnt3));
    run_vecs(14, vecs.size() - 1);
    check("underflow_cnt_4", 32'(underflow_cnt), 32'(exp_ucnt4));
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    mon_en = 1'b0;

    // Request generator: prefetch, handshakes, coincident event and clamp.
    do_reset();
    bcyc(1'b1, 1'b0, 1'b0);
    check("bv_before_fall", 32'(burst_valid), 32'h0);
    bcyc(1'b0, 1'b0, 1'b0);
    check("bv_fall_cycle", 32'(burst_valid), 32'h0);
    bcyc(1'b0, 1'b0, 1'b0);
    check("bv_prefetch", 32'(burst_valid), 32'h1);
    bcyc(1'b0, 1'b0, 1'b1);
    bcyc(1'b0, 1'b0, 1'b0);
    check("bv_pend1", 32'(burst_valid), 32'h1);
    bcyc(1'b0, 1'b1, 1'b0);
    bcyc(1'b0, 1'b0, 1'b1);
    bcyc(1'b0, 1'b0, 1'b0);
    check("bv_event_and_hs", 32'(burst_valid), 32'h1);
    bcyc(1'b0, 1'b0, 1'b1);
    bcyc(1'b0, 1'b0, 1'b0);
    check("bv_drained", 32'(burst_valid), 32'h0);
    for (int i = 0; i < 5; i++) begin
      bcyc(1'b0, 1'b1, 1'b0);
      bcyc(1'b0, 1'b0, 1'b0);
      bcyc(1'b0, 1'b0, 1'b0);
      check("req_drop_clamp", 32'(req_drop), (i == 4) ? 32'h1 : 32'h0);
    end
    n_hs = 0;
    for (int k = 0; k < 10; k++) begin
      bcyc(1'b0, 1'b0, 1'b1);
      if (burst_valid) n_hs++;
    end
    check("pend_clamped_at_max", 32'(n_hs), 32'd4);

    // Mid-line reset: outputs active, then reset clears them on the next edge.
    @(posedge video_clk);
    #1;
    vs_in = 1'b1; hs_in = 1'b1; de_in = 1'b1; data_req_in = 1'b1; burst_ready = 1'b0;
    @(negedge video_clk);
    @(posedge video_clk);
    #1;
    video_rst = 1'b1;
    @(negedge video_clk);
    check("pre_rst_vs_out", 32'(vs_out), 32'h1);
    check("pre_rst_hs_out", 32'(hs_out), 32'h1);
    check("pre_rst_de_out", 32'(de_out), 32'h1);
    @(negedge video_clk);
    check("midrst_vs_out", 32'(vs_out), 32'h0);
    check("midrst_hs_out", 32'(hs_out), 32'h0);
    check("midrst_de_out", 32'(de_out), 32'h0);
    check("midrst_pixel_out", 32'(pixel_out), 32'h0);
    check("midrst_req_drop", 32'(req_drop), 32'h0);
    check("midrst_burst_valid", 32'(burst_valid), 32'h0);
    check("midrst_underflow_cnt", 32'(underflow_cnt), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
